// File: rtl/test_unit_pkg.sv
// test_unit_pkg: shared state/result encodings and width helpers for the test unit sequencer
package test_unit_pkg;

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, FINISH} seq_state_e;

  typedef enum logic [1:0] {RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT} unit_result_e;

  // Counter width able to hold v, never narrower than one bit
  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  // Unit index / count width
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/unit_watchdog.sv
// unit_watchdog: loadable down-counter whose expire flag marks the last counted cycle
module unit_watchdog #(
  parameter int W = 4
) (
  input  logic         clock_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; counting stops at zero
  always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

  // Counter register
  always_ff @(posedge clock_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;

  assign expire_o = cnt_q == W'(1);

endmodule

// File: rtl/test_unit_sequencer.sv
// test_unit_sequencer: starts each test unit in turn, watchdogs it and aggregates the verdict
module test_unit_sequencer
  import test_unit_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int TIMEOUT   = 1024,
  parameter int GAP       = 2,
  localparam int UW       = idx_w(NUM_UNITS)
) (
  input  logic                 clock_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  output logic [NUM_UNITS-1:0] unit_start_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  input  logic [NUM_UNITS-1:0] unit_pass_i,
  output logic                 busy_o,
  output logic [UW-1:0]        cur_unit_o,
  output logic [NUM_UNITS-1:0] pass_mask_o,
  output logic [NUM_UNITS-1:0] fail_mask_o,
  output logic [NUM_UNITS-1:0] timeout_mask_o,
  output logic [UW-1:0]        pass_cnt_o,
  output logic                 all_done_o,
  output logic                 all_pass_o
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam int GW = cnt_w(GAP);
  localparam logic [UW-1:0] LAST = UW'(NUM_UNITS - 1);
  localparam logic [UW-1:0] FULL = UW'(NUM_UNITS);

  seq_state_e           state_q, state_d;
  unit_result_e         res;
  logic [UW-1:0]        cur_q, cur_d, cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] pass_q, pass_d, fail_q, fail_d, to_q, to_d, sel;
  logic                 tmr_exp, gap_exp, last, go, adv, fin;

  assign sel  = NUM_UNITS'(1) << cur_q;
  assign last = cur_q == LAST;
  assign go   = run_i && (state_q == IDLE || state_q == FINISH);
  assign fin  = res != RES_NONE;

  // Outcome of the current unit this cycle; done beats a coincident watchdog expiry
  always_comb
    res = (state_q != WAIT) ? RES_NONE :
          |(unit_done_i & sel) ? (|(unit_pass_i & sel) ? RES_PASS : RES_FAIL) :
          (TIMEOUT != 0 && tmr_exp) ? RES_TIMEOUT : RES_NONE;

  // Sequencing; GAP=0 skips the gap state entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FINISH:       state_d = run_i ? START : state_q;
      START:              state_d = WAIT;
      WAIT:               state_d = !fin ? WAIT : (GAP != 0) ? test_unit_pkg::GAP : last ? FINISH : START;
      test_unit_pkg::GAP: state_d = !gap_exp ? state_q : last ? FINISH : START;
      default:            state_d = IDLE;
    endcase
  end

  assign adv = state_d == START && (state_q == WAIT || state_q == test_unit_pkg::GAP);

  // Result bookkeeping; a new run clears everything from the previous sequence
  always_comb begin
    cur_d  = go ? '0 : adv ? cur_q + UW'(1) : cur_q;
    pass_d = go ? '0 : (res == RES_PASS) ? pass_q | sel : pass_q;
    fail_d = go ? '0 : (res == RES_FAIL) ? fail_q | sel : fail_q;
    to_d   = go ? '0 : (res == RES_TIMEOUT) ? to_q | sel : to_q;
    cnt_d  = go ? '0 : cnt_q + UW'(res == RES_PASS);
  end

  // State and result registers
  always_ff @(posedge clock_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end

  unit_watchdog #(.W(TW)) u_tmr (
    .clock_i  (clock_i),
    .rst_i    (rst_i),
    .load_i   (state_q == START),
    .en_i     (state_q == WAIT),
    .val_i    (TW'(TIMEOUT)),
    .expire_o (tmr_exp)
  );

  unit_watchdog #(.W(GW)) u_gap (
    .clock_i  (clock_i),
    .rst_i    (rst_i),
    .load_i   (fin),
    .en_i     (state_q == test_unit_pkg::GAP),
    .val_i    (GW'(GAP)),
    .expire_o (gap_exp)
  );

  assign unit_start_o   = (state_q == START) ? sel : '0;
  assign busy_o         = state_q != IDLE && state_q != FINISH;
  assign cur_unit_o     = cur_q;
  assign pass_mask_o    = pass_q;
  assign fail_mask_o    = fail_q;
  assign timeout_mask_o = to_q;
  assign pass_cnt_o     = cnt_q;
  assign all_done_o     = state_q == FINISH;
  assign all_pass_o     = all_done_o && cnt_q == FULL;

endmodule

// File: tb/tb_test_unit_sequencer.sv
// tb_test_unit_sequencer: randomized unit responders with a queue-based scoreboard
module tb_test_unit_sequencer;

  localparam int N = 8;
  localparam int T = 16;
  localparam int G = 2;

  typedef struct {
    bit         fin;
    int         unit;
    int         cyc;
    logic [N-1:0] pm, fm, tm;
    int         pc;
  } exp_t;

  logic clk = 0, rst = 1, run_drv = 0, run_noise = 0;
  logic [N-1:0] unit_start, unit_done = '0, unit_pass = '0;
  logic [N-1:0] pass_mask, fail_mask, timeout_mask;
  logic [3:0] cur_unit, pass_cnt;
  logic busy, all_done, all_pass;

  int cyc = 0;
  int n_cmp = 0, n_err = 0, fin_seen = 0;
  int dly_cfg[N];
  bit pas_cfg[N];
  bit noise_en = 0;
  exp_t q[$];

  test_unit_sequencer #(.NUM_UNITS(N), .TIMEOUT(T), .GAP(G)) dut (
    .clock_i        (clk),
    .rst_i          (rst),
    .run_i          (run_drv | run_noise),
    .unit_start_o   (unit_start),
    .unit_done_i    (unit_done),
    .unit_pass_i    (unit_pass),
    .busy_o         (busy),
    .cur_unit_o     (cur_unit),
    .pass_mask_o    (pass_mask),
    .fail_mask_o    (fail_mask),
    .timeout_mask_o (timeout_mask),
    .pass_cnt_o     (pass_cnt),
    .all_done_o     (all_done),
    .all_pass_o     (all_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Responder: models each unit from its configured delay/verdict and predicts the next DUT event
  int act_u = 0, st = -100, d_u, e_c, apc = 0;
  logic [N-1:0] apm = '0, afm = '0, atm = '0, real_d, spur;
  exp_t ne;
  always @(negedge clk) begin
    if (rst) begin
      unit_done = '0;
      unit_pass = '0;
      run_noise = 0;
      st = -100;
    end else begin
      if (unit_start != '0) begin
        for (int i = 0; i < N; i++) if (unit_start[i]) act_u = i;
        st = cyc;
        if (act_u == 0) begin apm = '0; afm = '0; atm = '0; apc = 0; end
        d_u = dly_cfg[act_u];
        if (d_u >= 1 && d_u <= T) begin
          e_c = st + d_u;
          if (pas_cfg[act_u]) begin apm[act_u] = 1'b1; apc++; end
          else afm[act_u] = 1'b1;
        end else begin
          e_c = st + T;
          atm[act_u] = 1'b1;
        end
        ne = '{act_u == N - 1, act_u + 1, e_c + G + 1, apm, afm, atm, apc};
        q.push_back(ne);
      end
      unit_pass = N'($urandom);
      real_d = '0;
      if (st >= 0 && dly_cfg[act_u] != 0 && cyc == st + dly_cfg[act_u]) begin
        real_d[act_u] = 1'b1;
        unit_pass[act_u] = pas_cfg[act_u];
      end
      spur = (noise_en && $urandom_range(3) == 0) ? N'($urandom) : '0;
      spur[act_u] = noise_en && cyc == st && $urandom_range(1) == 1;
      unit_done = real_d | spur;
      run_noise = noise_en && busy && $urandom_range(7) == 0;
    end
  end

  // Monitor: pops the expected event whenever the DUT emits a start pulse or raises all_done
  logic prev_done = 0;
  int m_idx;
  exp_t me;
  always @(negedge clk) begin
    if (rst) prev_done = 0;
    else begin
      chk("start_onehot0", 32'($onehot0(unit_start)), 1);
      if (unit_start != '0 || (all_done && !prev_done)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got start=%0h all_done=%0b required no event at cycle %0d", unit_start, all_done, cyc);
        end else begin
          me = q.pop_front();
          if (unit_start != '0) begin
            for (int i = 0; i < N; i++) if (unit_start[i]) m_idx = i;
            chk("event_is_start", 32'(me.fin), 0);
            chk("start_unit", m_idx, me.unit);
            chk("start_cycle", cyc, me.cyc);
            chk("cur_unit", cur_unit, me.unit);
            chk("busy_running", busy, 1);
          end else begin
            chk("event_is_finish", 32'(me.fin), 1);
            chk("finish_cycle", cyc, me.cyc);
            chk("pass_mask", pass_mask, me.pm);
            chk("fail_mask", fail_mask, me.fm);
            chk("timeout_mask", timeout_mask, me.tm);
            chk("pass_cnt", pass_cnt, me.pc);
            chk("all_pass", all_pass, me.pc == N);
            chk("busy_finish", busy, 0);
          end
        end
        if (all_done && !prev_done) fin_seen++;
      end
      prev_done = all_done;
    end
  end

  task automatic cfg_all(input int d, input bit p);
    for (int i = 0; i < N; i++) begin dly_cfg[i] = d; pas_cfg[i] = p; end
  endtask

  task automatic cfg_rand();
    for (int i = 0; i < N; i++) begin
      dly_cfg[i] = ($urandom_range(4) == 0) ? 0 : $urandom_range(T + 4, 1);
      pas_cfg[i] = 1'($urandom_range(1));
    end
  endtask

  task automatic kick();
    exp_t e;
    @(negedge clk);
    run_drv = 1;
    e = '{0, 0, cyc + 1, '0, '0, '0, 0};
    q.push_back(e);
    @(negedge clk);
    run_drv = 0;
  endtask

  task automatic run_seq();
    int f0;
    f0 = fin_seen;
    kick();
    for (int k = 0; k < 1000 && fin_seen == f0; k++) @(negedge clk);
    if (fin_seen == f0) begin
      n_cmp++;
      n_err++;
      $display("FAIL seq_timeout: got no all_done required all_done within 1000 cycles at cycle %0d", cyc);
      q.delete();
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, unit_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur"}, cur_unit, 0);
    chk({tag, "_masks"}, {pass_mask, fail_mask, timeout_mask}, 0);
    chk({tag, "_cnt"}, pass_cnt, 0);
    chk({tag, "_done"}, {all_done, all_pass}, 0);
  endtask

  initial begin
    cfg_all(5, 1);
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 0;
    @(negedge clk);
    chk_zero("post_rst");
    run_seq();
    pas_cfg[3] = 0;
    run_seq();
    cfg_all(5, 1);
    dly_cfg[5] = 0;
    run_seq();
    cfg_all(5, 1);
    dly_cfg[2] = T;
    pas_cfg[2] = 1'($urandom_range(1));
    noise_en = 1;
    run_seq();
    cfg_rand();
    run_seq();
    cfg_all(5, 1);
    dly_cfg[4] = 0;
    kick();
    for (int k = 0; k < 500 && !(busy && cur_unit == 4 && unit_start == '0); k++) @(negedge clk);
    chk("reached_unit4", cur_unit, 4);
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk_zero("abort");
    q.delete();
    @(negedge clk);
    chk_zero("abort_hold");
    rst = 0;
    @(negedge clk);
    chk_zero("abort_release");
    cfg_all(3, 1);
    run_seq();
    for (int s = 0; s < 6; s++) begin
      cfg_rand();
      run_seq();
    end
    noise_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
